// File: rtl/instmem_loader.sv
// instmem_loader: assembles a framed byte stream into 16-bit words and writes them to instruction memory
module instmem_loader #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [6:0]        words_written
);
    typedef enum logic [3:0] {
        IDLE, GET_ADDR, GET_CNT, GET_HI, GET_LO, WRITE, GET_CSUM, DONE, ERR
    } state_t;

    localparam logic [8:0] DEPTH9 = 9'(DEPTH);

    state_t            state, next;
    logic [ADDR_W-1:0] addr;
    logic [6:0]        cnt;
    logic [7:0]        hi, csum;
    logic              xfer, addr_bad, cnt_bad;

    assign byte_ready = state inside {GET_ADDR, GET_CNT, GET_HI, GET_LO, GET_CSUM};
    assign xfer       = byte_valid && byte_ready;
    assign mem_we     = state == WRITE;
    assign done       = state == DONE;
    assign cpu_hold   = state != IDLE;
    assign addr_bad   = {1'b0, byte_in} >= DEPTH9;
    assign cnt_bad    = byte_in == 8'd0 || {1'b0, byte_in} > DEPTH9
                        || 9'(addr) + {1'b0, byte_in} > DEPTH9;

    // state register; reset returns to IDLE at the next edge from anywhere
    always_ff @(posedge clk)
        state <= reset ? IDLE : next;

    // next-state: every byte state waits on a transfer, WRITE loops back until N words are done
    always_comb begin
        next = state;
        case (state)
            IDLE:     next = start ? GET_ADDR : IDLE;
            GET_ADDR: next = !xfer ? state : addr_bad ? ERR : GET_CNT;
            GET_CNT:  next = !xfer ? state : cnt_bad ? ERR : GET_HI;
            GET_HI:   next = xfer ? GET_LO : state;
            GET_LO:   next = xfer ? WRITE : state;
            WRITE:    next = words_written + 7'd1 == cnt ? GET_CSUM : GET_HI;
            GET_CSUM: next = !xfer ? state : byte_in == csum ? DONE : ERR;
            default:  next = IDLE;
        endcase
    end

    // datapath: latch frame fields, accumulate checksum, stage write address/data on the LO transfer
    always_ff @(posedge clk) begin
        if (reset) begin
            addr          <= '0;
            cnt           <= '0;
            hi            <= '0;
            csum          <= '0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            error         <= 1'b0;
            words_written <= '0;
        end else begin
            if (state == IDLE && start) begin
                error         <= 1'b0;
                words_written <= '0;
                csum          <= '0;
            end
            if (xfer && state == GET_ADDR) addr <= byte_in[ADDR_W-1:0];
            if (xfer && state == GET_CNT) cnt <= byte_in[6:0];
            if (xfer && state == GET_HI) begin
                hi   <= byte_in;
                csum <= csum ^ byte_in;
            end
            if (xfer && state == GET_LO) begin
                csum      <= csum ^ byte_in;
                mem_addr  <= addr;
                mem_wdata <= {hi, byte_in};
            end
            if (state == WRITE) begin
                addr          <= addr + 1'b1;
                words_written <= words_written + 7'd1;
            end
            if (next == ERR && state != ERR) error <= 1'b1;
        end
    end
endmodule

// File: tb/tb_instmem_loader.sv
// tb_instmem_loader: scoreboard bench driving framed byte streams into instmem_loader
module tb_instmem_loader;
    logic       clk = 1'b0;
    logic       reset, start, byte_valid, byte_ready, mem_we, cpu_hold, done, error;
    logic [7:0] byte_in;
    logic [5:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [6:0] words_written;

    int checks = 0, errors = 0, done_cnt = 0;
    logic [21:0] exp_q[$];
    logic [21:0] e;
    logic [7:0] fr[$];

    instmem_loader dut (
        .clk(clk), .reset(reset), .start(start), .byte_in(byte_in),
        .byte_valid(byte_valid), .byte_ready(byte_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_hold(cpu_hold),
        .done(done), .error(error), .words_written(words_written)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // write monitor: every mem_we must match the oldest expected write
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_we) begin
                check("ready_in_write", byte_ready, 0);
                if (exp_q.size() == 0) check("unexpected_we", mem_we, 0);
                else begin
                    e = exp_q.pop_front();
                    check("wr_addr", mem_addr, e[21:16]);
                    check("wr_data", mem_wdata, e[15:0]);
                end
            end
            if (done) done_cnt++;
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit tg);
        int t = 0;
        bit got = 0;
        if (tg) begin
            byte_valid = 1'b0;
            @(posedge clk); #1;
        end
        byte_in = b;
        byte_valid = 1'b1;
        while (!got && t < 50) begin
            @(negedge clk);
            got = byte_ready;
            t++;
        end
        if (!got) check("ready_timeout", byte_ready, 1);
        @(posedge clk); #1;
        byte_valid = 1'b0;
    endtask

    task automatic send_frame(input bit tg, input bit ms);
        int a = fr[0];
        int n = fr.size() > 1 ? int'(fr[1]) : 0;
        bit ok = a < 64 && n != 0 && a + n <= 64;
        pulse_start();
        check("hold_on_start", cpu_hold, 1);
        check("err_cleared", error, 0);
        for (int i = 0; i < fr.size(); i++) begin
            if (ms && i == 4) pulse_start();
            if (ok && i >= 3 && i <= 2 * n + 1 && i % 2 == 1)
                exp_q.push_back({6'(a + (i - 3) / 2), fr[i-1], fr[i]});
            send_byte(fr[i], tg);
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        while (cpu_hold && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("idle_timeout", cpu_hold, 0);
        @(posedge clk); #1;
    endtask

    task automatic run(input string tag, input bit tg, input bit ms, input int ed, input logic ee, input int ew);
        int d0 = done_cnt;
        send_frame(tg, ms);
        wait_idle();
        check({tag, "_done"}, done_cnt - d0, ed);
        check({tag, "_error"}, error, ee);
        check({tag, "_words"}, words_written, ew);
        check({tag, "_sb_empty"}, exp_q.size(), 0);
    endtask

    initial begin
        logic [7:0] c;
        reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_in = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", byte_ready, 0);
        check("rst_we", mem_we, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_words", words_written, 0);
        check("rst_hold", cpu_hold, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        fr = '{8'h05, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
        run("t1", 0, 0, 1, 0, 2);
        fr = '{8'h3F, 8'h01, 8'h5A, 8'hA5, 8'hFF};
        run("t2", 0, 0, 1, 0, 1);
        fr = '{8'h3E, 8'h03};
        run("t3_over", 0, 0, 0, 1, 0);
        fr = '{8'h05, 8'h00};
        run("t3_zero", 0, 0, 0, 1, 0);
        fr = '{8'h40};
        run("bad_addr", 0, 0, 0, 1, 0);
        fr = '{8'h00, 8'h41};
        run("cnt_65", 0, 0, 0, 1, 0);
        fr = '{8'h05, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
        run("t4_csum", 0, 0, 0, 1, 2);
        fr = '{8'h3F, 8'h01, 8'h5A, 8'hA5, 8'hFF};
        run("t4_clear", 0, 0, 1, 0, 1);

        fr = '{8'h00, 8'h40};
        c = '0;
        for (int i = 0; i < 128; i++) begin
            fr.push_back(8'($urandom));
            c ^= fr[fr.size()-1];
        end
        fr.push_back(c);
        run("full64", 0, 0, 1, 0, 64);

        pulse_start();
        send_byte(8'h05, 0);
        send_byte(8'h02, 0);
        send_byte(8'h12, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        check("t5_hold", cpu_hold, 0);
        check("t5_ready", byte_ready, 0);
        check("t5_words", words_written, 0);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("t5_sb_empty", exp_q.size(), 0);
        fr = '{8'h05, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
        run("t5_rerun", 0, 0, 1, 0, 2);

        run("t6_toggle", 1, 1, 1, 0, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
